io_input_port_ctrl: RTL and testbench
=====================================

# io_input_port_ctrl

Input-side peripheral that feeds the pipelined 8-bit CPU's `I_Port` and `int_sig` pins. It accepts bytes from an external producer over a valid/ready handshake and buffers them in a small FIFO. It presents the head byte on `I_Port`, raises a one-cycle interrupt per byte, and pops the byte when the CPU executes `IN`. It is the device end of the CPU input-port protocol that the CPU core consumes.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `HOLDOFF`, 2: idle cycles after a CPU read before the next interrupt pulse; ≥1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `src_data` in 8: producer byte.
- `src_valid` in 1: producer byte valid.
- `src_ready` out 1: block can accept.
- `cpu_in_rd` in 1: one-cycle strobe from the CPU `IN` stage; the CPU samples `I_Port` in the same cycle.
- `I_Port` out 8: head byte; 8'h00 when empty.
- `int_sig` out 1: interrupt request to the CPU.
- `fifo_level` out $clog2(DEPTH+1): occupied entries.
- `underrun` out 1: sticky; a read occurred while empty.

## Operation
- Push: on `src_valid && src_ready` at an edge. `src_ready = (fifo_level != DEPTH)`; there is no pass-through when full.
- Pop: on `cpu_in_rd` at an edge when not empty. The popped byte is the value on `I_Port` that cycle.
- Simultaneous push and pop when not empty: level unchanged. Push and pop when empty: push only, and the read counts as an underrun.
- `cpu_in_rd` when empty: `underrun` is set, `I_Port` reads 8'h00, and nothing else changes.
- Pointers wrap modulo `DEPTH`; level saturates by construction.
- IRQ FSM, with registered state:
  - S_IDLE: `int_sig`=0. When level ≠ 0, go to S_IRQ.
  - S_IRQ: `int_sig`=1 for exactly one cycle, then go to S_WAIT. A `cpu_in_rd` here goes to S_HOLD.
  - S_WAIT: `int_sig`=0. Wait for `cpu_in_rd`, which loads the hold counter with `HOLDOFF` and goes to S_HOLD.
  - S_HOLD: decrement the counter. At 0, go to S_IRQ if level ≠ 0, else S_IDLE. Reads in S_HOLD still pop (polled access) without extra pulses.
- Exactly one interrupt pulse per byte that becomes head under interrupt-driven use.

## Timing
- Reset values: `src_ready`=1, `I_Port`=8'h00, `int_sig`=0, `fifo_level`=0, `underrun`=0, FSM in S_IDLE, pointers 0.
- Reset mid-operation: contents discarded. A push coincident with the reset edge is dropped. An interrupt pulse in flight is cancelled.
- Push at edge N into an empty FIFO:
  - `I_Port` is valid after edge N.
  - `int_sig` is high between edges N+1 and N+2.
- Read at edge M in S_WAIT: the next pulse is no earlier than the cycle following edge M+`HOLDOFF`.
- `I_Port` and `src_ready` are combinational from registered state only. There is no combinational path from `cpu_in_rd` or `src_valid` to any output.

## Configuration
- `IO_IN_IRQ_EN` defined: the IRQ FSM and hold counter are built, and behaviour is as above.
- `IO_IN_IRQ_EN` undefined: the FSM is removed, `int_sig` is tied 0, and the block is polled only. FIFO, handshake and `underrun` are unchanged.

## Structure
- Package `io_pkg`:
  - FSM state enum (S_IDLE, S_IRQ, S_WAIT, S_HOLD).
  - Default `DEPTH` and `HOLDOFF` constants.
  - `IO_EMPTY_READ` = 8'h00.
- Sub-module `io_sync_fifo`: storage, pointers and level. The top holds the FSM, the underrun flag and the output muxing.

## Test plan
- **Reset:** reset, then release → all outputs at reset values; `src_ready`=1.
- **Single byte:** push 8'h5A at edge N → `I_Port`=8'h5A after N; `int_sig` pulses once at N+1. `cpu_in_rd` → `fifo_level`=0, `I_Port`=8'h00, and there is no further pulse.
- **Fill:** push 8'h01..8'h05 back-to-back with DEPTH=4 → the fifth is held with `src_ready`=0 and `fifo_level`=4. Then read four times with HOLDOFF=2 → bytes return in order 01..04, each pulse ≥3 cycles after the prior read, and 8'h05 is accepted after the first pop.
- **Underrun:** `cpu_in_rd` while empty → `underrun`=1 (sticky through later traffic), `I_Port`=8'h00, and the level stays 0.
- **Concurrent push and pop:** push and pop in the same cycle at level 2 → level stays 2; the head advances to the next byte.
- **Reset mid-operation and polled build:** `rst` asserted during S_IRQ with level 3 → `int_sig` 0 next cycle and the FIFO empties. Rebuilt without `IO_IN_IRQ_EN` → `int_sig` stays 0 across all of the above.

Source files
------------

// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared types and constants for the CPU input-port controller
package io_pkg;

    // Interrupt sequencer states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_IRQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } irq_state_t;

    localparam int IO_DEFAULT_DEPTH   = 4;
    localparam int IO_DEFAULT_HOLDOFF = 2;

    // Byte presented to the CPU when nothing is buffered
    localparam logic [7:0] IO_EMPTY_READ = 8'h00;

    // Width of a counter that must hold 0..depth inclusive
    function automatic int io_level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/io_sync_fifo.sv
// rtl/io_sync_fifo.sv - byte FIFO with wrapping pointers and occupancy level
module io_sync_fifo
    import io_pkg::*;
#(
    parameter int DEPTH = IO_DEFAULT_DEPTH,
    parameter int LW    = io_level_width(IO_DEFAULT_DEPTH)
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    head,
    output logic [LW-1:0] level,
    output logic          empty,
    output logic          full
);

    localparam int PW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] level_nxt;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Occupancy follows accepted pushes and pops; both together leave it unchanged
    always_comb begin
        level_nxt = level;
        case ({push_ok, pop_ok})
            2'b10:   level_nxt = level + LW'(1);
            2'b01:   level_nxt = level - LW'(1);
            default: level_nxt = level;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            level <= level_nxt;
        end
    end

    // Storage is not reset; a push coincident with reset is discarded
    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/io_input_port_ctrl.sv
// rtl/io_input_port_ctrl.sv - CPU input-port device: FIFO, interrupt sequencer (IO_IN_IRQ_EN), underrun flag
module io_input_port_ctrl
    import io_pkg::*;
#(
    parameter int  DEPTH   = IO_DEFAULT_DEPTH,
    parameter int  HOLDOFF = IO_DEFAULT_HOLDOFF,
    localparam int LW      = io_level_width(DEPTH)
)(
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    src_data,
    input  logic          src_valid,
    output logic          src_ready,
    input  logic          cpu_in_rd,
    output logic [7:0]    I_Port,
    output logic          int_sig,
    output logic [LW-1:0] fifo_level,
    output logic          underrun
);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("io_input_port_ctrl: DEPTH must be a power of two >= 2");
    end
    if (HOLDOFF < 1) begin : g_bad_holdoff
        $error("io_input_port_ctrl: HOLDOFF must be >= 1");
    end

    logic [7:0] fifo_head;
    logic       fifo_empty;
    logic       fifo_full;

    io_sync_fifo #(
        .DEPTH (DEPTH),
        .LW    (LW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (src_valid),
        .push_data (src_data),
        .pop       (cpu_in_rd),
        .head      (fifo_head),
        .level     (fifo_level),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Outputs depend only on registered FIFO state
    assign src_ready = !fifo_full;
    assign I_Port    = fifo_empty ? IO_EMPTY_READ : fifo_head;

    // Sticky record of any CPU read that found the FIFO empty
    always_ff @(posedge clk) begin
        if (rst) begin
            underrun <= 1'b0;
        end else if (cpu_in_rd && fifo_empty) begin
            underrun <= 1'b1;
        end
    end

`ifdef IO_IN_IRQ_EN
    localparam int HW = $clog2(HOLDOFF + 1);

    irq_state_t    state;
    irq_state_t    state_nxt;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_cnt_nxt;

    // State and hold counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    // One pulse per new head byte; a CPU read starts the hold-off window
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) state_nxt = S_IRQ;
            end
            S_IRQ: begin
                if (cpu_in_rd) begin
                    state_nxt    = S_HOLD;
                    hold_cnt_nxt = HW'(HOLDOFF);
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cpu_in_rd) begin
                    state_nxt    = S_HOLD;
                    hold_cnt_nxt = HW'(HOLDOFF);
                end
            end
            S_HOLD: begin
                if (hold_cnt == '0) begin
                    state_nxt = fifo_empty ? S_IDLE : S_IRQ;
                end else begin
                    hold_cnt_nxt = hold_cnt - HW'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Interrupt is asserted for the single cycle spent in S_IRQ
    always_comb begin
        int_sig = (state == S_IRQ);
    end
`else
    assign int_sig = 1'b0;
`endif

endmodule

// File: tb/tb_io_input_port_ctrl.sv
// tb/tb_io_input_port_ctrl.sv - self-checking bench for io_input_port_ctrl
module tb_io_input_port_ctrl;
    import io_pkg::*;

    localparam int DEPTH   = IO_DEFAULT_DEPTH;
    localparam int HOLDOFF = IO_DEFAULT_HOLDOFF;
    localparam int LW      = $clog2(DEPTH + 1);
`ifdef IO_IN_IRQ_EN
    localparam bit IRQ_BUILT = 1'b1;
`else
    localparam bit IRQ_BUILT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    src_data;
    logic          src_valid;
    logic          src_ready;
    logic          cpu_in_rd;
    logic [7:0]    I_Port;
    logic          int_sig;
    logic [LW-1:0] fifo_level;
    logic          underrun;

    io_input_port_ctrl #(
        .DEPTH   (DEPTH),
        .HOLDOFF (HOLDOFF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .src_data   (src_data),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .cpu_in_rd  (cpu_in_rd),
        .I_Port     (I_Port),
        .int_sig    (int_sig),
        .fifo_level (fifo_level),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int fails  = 0;
    int pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte queue plus interrupt timing expressed as edge stamps
    logic [7:0] mq[$];
    bit         m_live    = 1'b0;
    bit         m_under   = 1'b0;
    bit         m_int     = 1'b0;
    bit         m_waiting = 1'b0;
    int         m_release = 0;
    int         k         = 0;
    int         lvl_b;
    bit         int_b;
    bit         fire;
    logic [7:0] junk;

    always @(posedge clk) begin
        k++;
        if (rst) begin
            mq.delete();
            m_live    = 1'b1;
            m_under   = 1'b0;
            m_int     = 1'b0;
            m_waiting = 1'b0;
            m_release = 0;
        end else if (m_live) begin
            lvl_b = mq.size();
            int_b = m_int;
            fire  = 1'b0;
            if (cpu_in_rd && lvl_b == 0) m_under = 1'b1;
            if (cpu_in_rd && lvl_b != 0) junk = mq.pop_front();
            if (src_valid && lvl_b != DEPTH) mq.push_back(src_data);
            if (int_b) begin
                if (cpu_in_rd) m_release = k + HOLDOFF + 1;
                else           m_waiting = 1'b1;
            end else if (m_waiting) begin
                if (cpu_in_rd) begin
                    m_waiting = 1'b0;
                    m_release = k + HOLDOFF + 1;
                end
            end else if (k >= m_release && lvl_b != 0) begin
                fire = 1'b1;
            end
            m_int = IRQ_BUILT && fire;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (int_sig === 1'b1) pulses++;
        if (m_live) begin
            check("cyc_iport", 32'(I_Port), 32'((mq.size() != 0) ? mq[0] : 8'h00));
            check("cyc_level", 32'(fifo_level), 32'(mq.size()));
            check("cyc_ready", 32'(src_ready), 32'(mq.size() != DEPTH));
            check("cyc_int", 32'(int_sig), 32'(m_int));
            check("cyc_under", 32'(underrun), 32'(m_under));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_int(input string name);
        int n = 0;
        while (int_sig !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        check({name, "_irq_seen"}, 32'(n < 30), 32'd1);
    endtask

    task automatic push1(input logic [7:0] d);
        src_data  = d;
        src_valid = 1'b1;
        tick();
        src_valid = 1'b0;
    endtask

    task automatic read_byte(output logic [7:0] b);
        cpu_in_rd = 1'b1;
        b = I_Port;
        tick();
        cpu_in_rd = 1'b0;
    endtask

    logic [7:0] b;
    int         p0;

    initial begin
        rst       = 1'b1;
        src_valid = 1'b0;
        src_data  = 8'h00;
        cpu_in_rd = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset values
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_iport", 32'(I_Port), 32'h00);
        check("rst_ready", 32'(src_ready), 32'd1);
        check("rst_int", 32'(int_sig), 32'd0);
        check("rst_under", 32'(underrun), 32'd0);

        // Single byte: head visible after the push edge, one pulse one edge later
        p0 = pulses;
        push1(8'h5A);
        check("single_iport", 32'(I_Port), 32'h5A);
        check("single_level", 32'(fifo_level), 32'd1);
        check("single_int_n", 32'(int_sig), 32'd0);
        tick();
        check("single_int_n1", 32'(int_sig), 32'(IRQ_BUILT));
        tick();
        check("single_int_n2", 32'(int_sig), 32'd0);
        tick();
        read_byte(b);
        check("single_byte", 32'(b), 32'h5A);
        check("single_drained", 32'(fifo_level), 32'd0);
        check("single_iport0", 32'(I_Port), 32'h00);
        repeat (6) tick();
        check("single_pulses", 32'(pulses - p0), 32'(IRQ_BUILT));

        // Fill beyond DEPTH; fifth byte stays offered until space appears
        for (int i = 1; i <= 5; i++) begin
            src_data  = 8'(i);
            src_valid = 1'b1;
            tick();
        end
        check("fill_level", 32'(fifo_level), 32'd4);
        check("fill_ready", 32'(src_ready), 32'd0);
        for (int r = 0; r < 4; r++) begin
            if (r != 0) begin
`ifdef IO_IN_IRQ_EN
                wait_int("fill");
                tick();
`else
                repeat (3) tick();
`endif
            end
            read_byte(b);
            check("fill_order", 32'(b), 32'(r + 1));
            if (r == 0) begin
                tick();
                src_valid = 1'b0;
                check("fill_refill", 32'(fifo_level), 32'd4);
            end
        end
`ifdef IO_IN_IRQ_EN
        wait_int("fill5");
        tick();
`else
        repeat (3) tick();
`endif
        read_byte(b);
        check("fill_fifth", 32'(b), 32'h05);
        check("fill_empty", 32'(fifo_level), 32'd0);

        // Underrun: read while empty
        cpu_in_rd = 1'b1;
        check("under_iport", 32'(I_Port), 32'h00);
        tick();
        cpu_in_rd = 1'b0;
        check("under_flag", 32'(underrun), 32'd1);
        check("under_level", 32'(fifo_level), 32'd0);
        push1(8'hCC);
        repeat (4) tick();
        read_byte(b);
        check("under_next", 32'(b), 32'hCC);
        check("under_sticky", 32'(underrun), 32'd1);

        // Concurrent push and pop at level 2
        push1(8'hAA);
        push1(8'hBB);
        check("conc_pre", 32'(fifo_level), 32'd2);
        src_data  = 8'hDD;
        src_valid = 1'b1;
        cpu_in_rd = 1'b1;
        b = I_Port;
        tick();
        src_valid = 1'b0;
        cpu_in_rd = 1'b0;
        check("conc_pop", 32'(b), 32'hAA);
        check("conc_level", 32'(fifo_level), 32'd2);
        check("conc_head", 32'(I_Port), 32'hBB);

        // Build level 3 so the next pulse lands with three bytes queued
        push1(8'hEE);
        read_byte(b);
        check("mid_pop", 32'(b), 32'hBB);
        push1(8'hFF);
`ifdef IO_IN_IRQ_EN
        wait_int("mid");
`else
        repeat (3) tick();
`endif
        check("mid_level", 32'(fifo_level), 32'd3);
        check("mid_int", 32'(int_sig), 32'(IRQ_BUILT));

        // Reset with a coincident push: pulse cancelled, contents and push dropped
        rst       = 1'b1;
        src_data  = 8'h77;
        src_valid = 1'b1;
        tick();
        rst       = 1'b0;
        src_valid = 1'b0;
        check("mrst_int", 32'(int_sig), 32'd0);
        check("mrst_level", 32'(fifo_level), 32'd0);
        check("mrst_iport", 32'(I_Port), 32'h00);
        check("mrst_ready", 32'(src_ready), 32'd1);
        check("mrst_under", 32'(underrun), 32'd0);
        tick();
        check("mrst_dropped", 32'(fifo_level), 32'd0);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
